// File: rtl/mii_pkg.sv
// Shared definitions for the MII frame receiver: FSM encoding, CRC-32 constants,
// preamble/SFD byte values and status error bit positions.
package mii_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } rx_state_t;

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  localparam logic [7:0] PREAMBLE = 8'h55;
  localparam logic [7:0] SFD      = 8'hD5;

  localparam int ERR_CRC      = 0;
  localparam int ERR_RUNT     = 1;
  localparam int ERR_OVERSIZE = 2;
  localparam int ERR_ALIGN    = 3;

  // Assemble the status error vector from individual flags.
  function automatic logic [3:0] pack_err(input logic align, input logic oversize,
                                          input logic runt, input logic crc);
    logic [3:0] e;
    e               = 4'b0000;
    e[ERR_ALIGN]    = align;
    e[ERR_OVERSIZE] = oversize;
    e[ERR_RUNT]     = runt;
    e[ERR_CRC]      = crc;
    return e;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wise reflected Ethernet CRC-32 next-state function (LSB of the byte first).
module crc32_d8
  import mii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  logic [31:0] c_s;

  // Eight serial LFSR steps unrolled into one combinational stage.
  always_comb begin
    c_s = crc_in;
    for (int i = 0; i < 8; i++) begin
      c_s = (c_s[0] ^ d[i]) ? ((c_s >> 1) ^ CRC_POLY) : (c_s >> 1);
    end
    crc_out = c_s;
  end

endmodule

// File: rtl/mii_frame_rx.sv
// MII receive framer: strips preamble/SFD/FCS, checks CRC and length, reports
// per-frame status and keeps good/bad frame counters.
module mii_frame_rx
  import mii_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rxd,
  input  logic        rx_dv,
  output logic [7:0]  data_out,
  output logic        data_vld,
  output logic        sop,
  output logic        eop,
  output logic        stat_vld,
  output logic [15:0] stat_len,
  output logic [3:0]  stat_err,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam logic [15:0] MIN_LEN_C = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);
  localparam logic [2:0]  DL_DEPTH  = 3'd5;

  rx_state_t   state_r;
  logic [31:0] crc_r;
  logic [15:0] len_r;
  logic [2:0]  held_r;
  logic        first_r;
  logic [7:0]  dl_r [0:4];

  logic [31:0] crc_next_s;
  logic [15:0] len_inc_s;
  logic [3:0]  frame_err_s;
  logic        held_full_s;

  crc32_d8 u_crc (
    .crc_in  (crc_r),
    .d       (rxd),
    .crc_out (crc_next_s)
  );

  // Saturating length increment and end-of-frame error evaluation.
  always_comb begin
    len_inc_s   = (len_r == 16'hFFFF) ? len_r : (len_r + 16'd1);
    held_full_s = (held_r == DL_DEPTH);
    frame_err_s = pack_err(1'b0, (len_r > MAX_LEN_C), (len_r < MIN_LEN_C),
                           (crc_r != CRC_RESIDUE));
  end

  // Receive FSM, delay line, status and counters; all outputs registered here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= IDLE;
      crc_r    <= CRC_INIT;
      len_r    <= 16'd0;
      held_r   <= 3'd0;
      first_r  <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        dl_r[i] <= 8'h00;
      end
      data_out <= 8'h00;
      data_vld <= 1'b0;
      sop      <= 1'b0;
      eop      <= 1'b0;
      stat_vld <= 1'b0;
      stat_len <= 16'd0;
      stat_err <= 4'b0000;
      good_cnt <= 16'd0;
      bad_cnt  <= 16'd0;
    end else begin
      data_vld <= 1'b0;
      sop      <= 1'b0;
      eop      <= 1'b0;
      stat_vld <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rx_dv) begin
            if (rxd == PREAMBLE) begin
              state_r <= PRE;
            end else begin
              state_r <= DROP;
            end
          end
        end
        PRE: begin
          if (!rx_dv) begin
            state_r  <= IDLE;
            stat_vld <= 1'b1;
            stat_len <= 16'd0;
            stat_err <= pack_err(1'b1, 1'b0, 1'b0, 1'b0);
            bad_cnt  <= bad_cnt + 16'd1;
          end else if (rxd == SFD) begin
            state_r <= DATA;
            crc_r   <= CRC_INIT;
            len_r   <= 16'd0;
            held_r  <= 3'd0;
            first_r <= 1'b1;
          end else if (rxd != PREAMBLE) begin
            state_r <= DROP;
          end
        end
        DATA: begin
          if (rx_dv) begin
            crc_r <= crc_next_s;
            len_r <= len_inc_s;
            for (int i = 4; i > 0; i--) begin
              dl_r[i] <= dl_r[i-1];
            end
            dl_r[0] <= rxd;
            if (held_full_s) begin
              data_out <= dl_r[4];
              data_vld <= 1'b1;
              sop      <= first_r;
              first_r  <= 1'b0;
            end else begin
              held_r <= held_r + 3'd1;
            end
          end else begin
            // Frame end: the last payload byte leaves with the status; the
            // four bytes still held are the FCS and are dropped.
            state_r  <= IDLE;
            stat_vld <= 1'b1;
            stat_len <= len_r;
            stat_err <= frame_err_s;
            if (frame_err_s != 4'b0000) begin
              bad_cnt <= bad_cnt + 16'd1;
            end else begin
              good_cnt <= good_cnt + 16'd1;
            end
            if (held_full_s) begin
              data_out <= dl_r[4];
              data_vld <= 1'b1;
              sop      <= first_r;
              eop      <= 1'b1;
            end
            held_r  <= 3'd0;
            first_r <= 1'b0;
          end
        end
        DROP: begin
          if (!rx_dv) begin
            state_r  <= IDLE;
            stat_vld <= 1'b1;
            stat_len <= 16'd0;
            stat_err <= pack_err(1'b1, 1'b0, 1'b0, 1'b0);
            bad_cnt  <= bad_cnt + 16'd1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
